// File: rtl/fmul_pkg.sv
// Shared types and defaults for the FloatMul mantissa path.
package fmul_pkg;

  localparam int unsigned MANT_W     = 16;
  localparam int unsigned ITER_CNT_W = 5;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/mant_mul_seq_ctrl_if.sv
// Start/ready request and held-result bundle for the iterative mantissa multiplier.
interface mant_mul_seq_ctrl_if
  import fmul_pkg::*;
#(
  parameter int unsigned W = MANT_W
);

  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           ready;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;
  logic           norm;

  modport master (
    output start, a, b,
    input  ready, busy, done, product, norm
  );

  modport slave (
    input  start, a, b,
    output ready, busy, done, product, norm
  );

endinterface

// File: rtl/mant_add16.sv
// Combinational W-bit kill/propagate/generate prefix adder with carry-in; result is {cout, sum}.
module mant_add16
  import fmul_pkg::*;
#(
  parameter int unsigned W = MANT_W
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W:0]   sum_o
);

  localparam int unsigned NumLevels = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0] hp;
  logic [W-1:0] g_lv [NumLevels+1];
  logic [W-1:0] p_lv [NumLevels+1];

  always_comb begin
    hp      = a_i ^ b_i;
    g_lv[0] = a_i & b_i;
    p_lv[0] = hp;
    // Carry-in folded into bit 0, which then becomes a resolved generate/kill.
    g_lv[0][0] = (a_i[0] & b_i[0]) | (hp[0] & cin_i);
    p_lv[0][0] = 1'b0;
    for (int l = 0; l < int'(NumLevels); l++) begin
      for (int i = 0; i < int'(W); i++) begin
        if (i >= (1 << l)) begin
          g_lv[l+1][i] = g_lv[l][i] | (p_lv[l][i] & g_lv[l][i-(1<<l)]);
          p_lv[l+1][i] = p_lv[l][i] & p_lv[l][i-(1<<l)];
        end else begin
          g_lv[l+1][i] = g_lv[l][i];
          p_lv[l+1][i] = p_lv[l][i];
        end
      end
    end
    sum_o = {g_lv[NumLevels][W-1], hp ^ {g_lv[NumLevels][W-2:0], cin_i}};
  end

endmodule

// File: rtl/mant_mul_seq_ctrl.sv
// Shift-add sequencer for the unsigned mantissa multiplier: one shared adder, W iterations.
module mant_mul_seq_ctrl
  import fmul_pkg::*;
#(
  parameter int unsigned W     = MANT_W,
  parameter int unsigned CNT_W = ITER_CNT_W
) (
  input logic               clk,
  input logic               rst,
  mant_mul_seq_ctrl_if.slave bus
);

  if ((1 << CNT_W) <= W) begin : gen_cnt_w_check
    $error("CNT_W too narrow to count W iterations");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [W-1:0]     mcand_q, mcand_d;
  // Bit 2W of the partial product is always zero after a shift, so it is not stored.
  logic [2*W-1:0]   p_q, p_d;
  logic [2*W-1:0]   product_q, product_d;
  logic             norm_q, norm_d;
  logic [W:0]       add_res;
  logic [W:0]       acc;
  logic [2*W-1:0]   p_shift;

  mant_add16 #(.W(W)) u_add (
    .a_i  (p_q[2*W-1:W]),
    .b_i  (mcand_q),
    .cin_i(1'b0),
    .sum_o(add_res)
  );

  assign acc     = p_q[0] ? add_res : {1'b0, p_q[2*W-1:W]};
  assign p_shift = {acc, p_q[W-1:1]};

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    mcand_d   = mcand_q;
    p_d       = p_q;
    product_d = product_q;
    norm_d    = norm_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          mcand_d = bus.a;
          p_d     = {{W{1'b0}}, bus.b};
          count_d = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        p_d     = p_shift;
        count_d = count_q + 1'b1;
        if (count_q == CNT_W'(W - 1)) begin
          product_d = p_shift;
          norm_d    = p_shift[2*W-1];
          state_d   = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      count_q   <= '0;
      mcand_q   <= '0;
      p_q       <= '0;
      product_q <= '0;
      norm_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      mcand_q   <= mcand_d;
      p_q       <= p_d;
      product_q <= product_d;
      norm_q    <= norm_d;
    end
  end

  assign bus.ready   = (state_q == StIdle);
  assign bus.busy    = (state_q == StRun);
  assign bus.done    = (state_q == StDone);
  assign bus.product = product_q;
  assign bus.norm    = norm_q;

endmodule

// File: tb/tb_mant_mul_seq_ctrl.sv
// Bench for mant_mul_seq_ctrl: vector table, corner-case sequences and a result scoreboard.
module tb_mant_mul_seq_ctrl;

  localparam int unsigned W     = 16;
  localparam int          Lat   = W + 1;
  localparam int          Bound = 60;
  localparam int          NRand = 1500;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] prod;
    logic        norm;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mant_mul_seq_ctrl_if #(.W(W)) bus ();

  mant_mul_seq_ctrl #(.W(W), .CNT_W(5)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  vec_t        vecs[6];
  logic [32:0] sb[$];
  logic [32:0] mon_e;
  logic [31:0] last_prod;
  logic [15:0] ra, rb;
  logic [31:0] rp;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Scoreboard: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'(bus.done), 64'(0));
      end else begin
        mon_e = sb.pop_front();
        check("product", 64'(bus.product), 64'(mon_e[31:0]));
        check("norm", 64'(bus.norm), 64'(mon_e[32]));
      end
    end
  end

  task automatic do_op(input logic [15:0] oa, input logic [15:0] ob, input logic [31:0] ep,
                       input logic en);
    int cyc;
    check("ready_idle", 64'(bus.ready), 64'(1));
    bus.start = 1'b1;
    bus.a     = oa;
    bus.b     = ob;
    sb.push_back({en, ep});
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = ~oa;
    bus.b     = ~ob;
    cyc       = 1;
    while (bus.done !== 1'b1 && cyc < Bound) begin
      if (cyc == 8) check("product_held", 64'(bus.product), 64'(last_prod));
      @(negedge clk);
      cyc++;
    end
    check("latency", 64'(cyc), 64'(Lat));
    last_prod = ep;
    @(negedge clk);
    check("done_1cyc", 64'(bus.done), 64'(0));
    check("ready_back", 64'(bus.ready), 64'(1));
  endtask

  task automatic wait_done(input string nm);
    int cyc = 0;
    while (bus.done !== 1'b1 && cyc < Bound) begin
      @(negedge clk);
      cyc++;
    end
    check(nm, 64'(bus.done), 64'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'h0003, 16'h0005, 32'h0000000F, 1'b0};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b1};
    vecs[2] = '{16'h8000, 16'h8000, 32'h40000000, 1'b0};
    vecs[3] = '{16'hC000, 16'hC000, 32'h90000000, 1'b1};
    vecs[4] = '{16'h1234, 16'h0000, 32'h00000000, 1'b0};
    vecs[5] = '{16'h0000, 16'hABCD, 32'h00000000, 1'b0};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    last_prod = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 64'(bus.ready), 64'(1));
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_product", 64'(bus.product), 64'(0));
    check("rst_norm", 64'(bus.norm), 64'(0));

    foreach (vecs[i]) do_op(vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].norm);

    // Second request during RUN must be dropped, not queued.
    check("ovl_ready", 64'(bus.ready), 64'(1));
    bus.start = 1'b1;
    bus.a     = 16'h0002;
    bus.b     = 16'h0003;
    sb.push_back({1'b0, 32'h00000006});
    @(negedge clk);
    bus.a = 16'hFFFF;
    bus.b = 16'hFFFF;
    check("ovl_busy", 64'(bus.busy), 64'(1));
    repeat (10) @(negedge clk);
    bus.start = 1'b0;
    wait_done("ovl_done");
    last_prod = 32'h00000006;
    repeat (3) begin
      @(negedge clk);
      check("ovl_ignored", 64'(bus.busy), 64'(0));
    end

    // start held high: re-accept in the IDLE cycle right after DONE.
    bus.start = 1'b1;
    bus.a     = 16'h0003;
    bus.b     = 16'h0005;
    sb.push_back({1'b0, 32'h0000000F});
    sb.push_back({1'b0, 32'h0000000F});
    wait_done("hold_done1");
    @(negedge clk);
    check("hold_idle", 64'(bus.ready), 64'(1));
    @(negedge clk);
    check("hold_reaccept", 64'(bus.busy), 64'(1));
    bus.start = 1'b0;
    wait_done("hold_done2");
    @(negedge clk);
    last_prod = 32'h0000000F;

    // Reset in place of iteration 8: operation discarded, no done.
    bus.start = 1'b1;
    bus.a     = 16'h00FF;
    bus.b     = 16'h00FF;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    check("mid_busy", 64'(bus.busy), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_ready", 64'(bus.ready), 64'(1));
    check("mid_busy0", 64'(bus.busy), 64'(0));
    check("mid_done", 64'(bus.done), 64'(0));
    check("mid_product", 64'(bus.product), 64'(0));
    check("mid_norm", 64'(bus.norm), 64'(0));
    last_prod = '0;
    repeat (3) @(negedge clk);
    do_op(16'h00FF, 16'h00FF, 32'h0000FE01, 1'b0);

    for (int i = 0; i < NRand; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rp = 32'(ra) * 32'(rb);
      do_op(ra, rb, rp, rp[31]);
    end

    repeat (2) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
